// File: rtl/mtr_drv_pkg.sv
// Shared widths, limits and FSM encoding for the motor PWM gate driver.
package mtr_drv_pkg;

  localparam int PWM_W = 11;
  localparam logic [PWM_W-1:0] PWM_MAX = 11'h7FF;

  typedef enum logic [1:0] {
    DEAD = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } nonovl_state_t;

  // Magnitude of a signed speed command; -2048 has no 11-bit magnitude so it clips to full scale.
  function automatic logic [PWM_W-1:0] abs_sat(input logic [PWM_W:0] spd);
    logic [PWM_W:0] mag;
    mag = spd[PWM_W] ? (~spd + 1'b1) : spd;
    if (mag[PWM_W]) abs_sat = PWM_MAX;
    else            abs_sat = mag[PWM_W-1:0];
  endfunction

endpackage

// File: rtl/mtr_pwm_drv_nonovl.sv
// Dead-time generator: turns one raw PWM into complementary high/low gate drives
// that are never on together and are separated by NONOVERLAP idle cycles.
module pwm_nonovl
  import mtr_drv_pkg::*;
#(
  parameter int NONOVERLAP = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic en,
  output logic hi,
  output logic lo
);

  localparam logic [7:0] DEAD_LAST = 8'(NONOVERLAP - 1);

  nonovl_state_t state;
  logic [7:0]    dcnt;
  logic          raw_q;

  // hi/lo are updated in lock-step with state so they always equal its decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DEAD;
      dcnt  <= '0;
      raw_q <= 1'b0;
      hi    <= 1'b0;
      lo    <= 1'b0;
    end else begin
      raw_q <= raw;
      if (!en) begin
        state <= DEAD;
        dcnt  <= '0;
        hi    <= 1'b0;
        lo    <= 1'b0;
      end else begin
        case (state)
          DEAD: begin
            if (raw != raw_q) begin
              dcnt <= '0;
            end else if (dcnt == DEAD_LAST) begin
              state <= raw ? HI : LO;
              hi    <= raw;
              lo    <= ~raw;
            end else begin
              dcnt <= dcnt + 8'd1;
            end
          end
          HI: begin
            if (!raw) begin
              state <= DEAD;
              dcnt  <= '0;
              hi    <= 1'b0;
            end
          end
          LO: begin
            if (raw) begin
              state <= DEAD;
              dcnt  <= '0;
              lo    <= 1'b0;
            end
          end
          default: begin
            state <= DEAD;
            dcnt  <= '0;
            hi    <= 1'b0;
            lo    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/mtr_pwm_drv.sv
// Two-wheel H-bridge driver: period counter, per-period shadowed duty/direction,
// PWM compare and a dead-time generator per side.
module mtr_pwm_drv
  import mtr_drv_pkg::*;
#(
  parameter int NONOVERLAP = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        mtr_en,
  output logic        lft_hi,
  output logic        lft_lo,
  output logic        rght_hi,
  output logic        rght_lo,
  output logic        lft_rev,
  output logic        rght_rev,
  output logic        pwm_synch
);

  logic [PWM_W-1:0] cnt;
  logic [PWM_W-1:0] lft_duty;
  logic [PWM_W-1:0] rght_duty;
  logic             wrap;
  logic             lft_raw;
  logic             rght_raw;

  assign wrap = (cnt == PWM_MAX);

  // Commands are only sampled on the last count so a period never mixes two duties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      pwm_synch <= 1'b0;
      lft_duty  <= '0;
      rght_duty <= '0;
      lft_rev   <= 1'b0;
      rght_rev  <= 1'b0;
    end else begin
      cnt       <= cnt + 1'b1;
      pwm_synch <= wrap;
      if (wrap) begin
        lft_duty  <= abs_sat(lft_spd);
        rght_duty <= abs_sat(rght_spd);
        lft_rev   <= lft_spd[11];
        rght_rev  <= rght_spd[11];
      end
    end
  end

  assign lft_raw  = (cnt < lft_duty);
  assign rght_raw = (cnt < rght_duty);

  pwm_nonovl #(.NONOVERLAP(NONOVERLAP)) u_lft_nonovl (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (lft_raw),
    .en    (mtr_en),
    .hi    (lft_hi),
    .lo    (lft_lo)
  );

  pwm_nonovl #(.NONOVERLAP(NONOVERLAP)) u_rght_nonovl (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (rght_raw),
    .en    (mtr_en),
    .hi    (rght_hi),
    .lo    (rght_lo)
  );

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Bench for mtr_pwm_drv: per-period drive counts are scored against hand-computed
// expectations queued by the stimulus, plus direct reset/enable timing checks.
module tb_mtr_pwm_drv;

  logic        clk;
  logic        rst_n;
  logic [11:0] lft_spd;
  logic [11:0] rght_spd;
  logic        mtr_en;
  logic        lft_hi;
  logic        lft_lo;
  logic        rght_hi;
  logic        rght_lo;
  logic        lft_rev;
  logic        rght_rev;
  logic        pwm_synch;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mtr_pwm_drv #(.NONOVERLAP(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd),
    .mtr_en    (mtr_en),
    .lft_hi    (lft_hi),
    .lft_lo    (lft_lo),
    .rght_hi   (rght_hi),
    .rght_lo   (rght_lo),
    .lft_rev   (lft_rev),
    .rght_rev  (rght_rev),
    .pwm_synch (pwm_synch)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [15:0] per;
    logic        side;
    logic [11:0] e_hi;
    logic [11:0] e_lo;
    logic [11:0] e_idle;
    logic        e_rev;
  } exp_t;

  localparam logic [11:0] DC = 12'hFFF;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cur_per = 0;
  int   len;
  int   ovl_n;
  int   hi_n[2];
  int   lo_n[2];
  int   idle_n[2];
  logic rev_s[2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int per, input bit side, input int h, input int l,
                      input int i, input bit rev);
    exp_t e;
    e.per    = 16'(per);
    e.side   = side;
    e.e_hi   = 12'(h);
    e.e_lo   = 12'(l);
    e.e_idle = 12'(i);
    e.e_rev  = rev;
    exp_q.push_back(e);
  endtask

  task automatic clear_counts();
    len   = 0;
    ovl_n = 0;
    for (int s = 0; s < 2; s++) begin
      hi_n[s]   = 0;
      lo_n[s]   = 0;
      idle_n[s] = 0;
    end
  endtask

  task automatic finalize(input int p);
    exp_t  e;
    string sd;
    chk($sformatf("p%0d length", p), len, 2048);
    chk($sformatf("p%0d overlap", p), ovl_n, 0);
    while (exp_q.size() > 0 && int'(exp_q[0].per) <= p) begin
      e = exp_q.pop_front();
      if (int'(e.per) < p) chk("stale expectation period", int'(e.per), p);
      sd = e.side ? "R" : "L";
      if (e.e_hi != DC)   chk($sformatf("p%0d %s hi", p, sd), hi_n[e.side], int'(e.e_hi));
      if (e.e_lo != DC)   chk($sformatf("p%0d %s lo", p, sd), lo_n[e.side], int'(e.e_lo));
      if (e.e_idle != DC) chk($sformatf("p%0d %s idle", p, sd), idle_n[e.side], int'(e.e_idle));
      chk($sformatf("p%0d %s rev", p, sd), int'(rev_s[e.side]), int'(e.e_rev));
    end
  endtask

  // Monitor: a period window opens on each pwm_synch sample.
  always @(negedge clk) begin
    if (!rst_n) begin
      cur_per = 0;
      clear_counts();
    end else begin
      if (pwm_synch) begin
        if (cur_per > 0) finalize(cur_per);
        cur_per++;
        clear_counts();
        rev_s[0] = lft_rev;
        rev_s[1] = rght_rev;
      end
      len++;
      ovl_n     += int'(lft_hi & lft_lo) + int'(rght_hi & rght_lo);
      hi_n[0]   += int'(lft_hi);
      lo_n[0]   += int'(lft_lo);
      idle_n[0] += int'(!lft_hi && !lft_lo);
      hi_n[1]   += int'(rght_hi);
      lo_n[1]   += int'(rght_lo);
      idle_n[1] += int'(!rght_hi && !rght_lo);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_per(input int p);
    int n;
    n = 0;
    while (cur_per < p && n < 3 * 2048) begin
      tick();
      n++;
    end
    if (cur_per < p) chk("wait for period start", cur_per, p);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   n;
    logic seen;

    rst_n    = 1'b0;
    lft_spd  = 12'h400;
    rght_spd = 12'h400;
    mtr_en   = 1'b1;
    repeat (3) tick();
    chk("reset state outputs",
        int'({lft_hi, lft_lo, rght_hi, rght_lo, lft_rev, rght_rev, pwm_synch}), 0);
    rst_n = 1'b1;

    n = 0;
    while (!lft_hi && n < 5000) begin
      tick();
      n++;
    end
    chk("lft_hi reached before reset", int'(lft_hi), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset mid-HI outputs",
        int'({lft_hi, lft_lo, rght_hi, rght_lo, lft_rev, rght_rev, pwm_synch}), 0);

    lft_spd  = 12'h000;
    rght_spd = 12'h000;
    repeat (3) tick();
    rst_n = 1'b1;
    n     = 0;
    seen  = 1'b0;
    while (!lft_lo && n < 200) begin
      tick();
      n++;
      seen = seen | lft_hi | rght_hi;
    end
    chk("lo rise after reset release", n, 32);
    chk("rght_lo rises with lft_lo", int'(rght_lo), 1);
    chk("hi during initial dead time", int'(seen), 0);

    push(1, 0, 0, 2048, 0, 0);
    push(1, 1, 0, 2048, 0, 0);
    push(2, 0, 0, 2048, 0, 0);
    push(2, 1, 0, 2048, 0, 0);

    // Half duty on the left, negative full scale on the right.
    wait_per(2);
    lft_spd  = 12'h400;
    rght_spd = 12'h800;
    push(3, 0, DC, DC, DC, 0);
    push(3, 1, DC, DC, DC, 1);
    push(4, 0, 992, 992, 64, 0);
    push(4, 1, 2015, 0, 33, 1);

    // Mid-period command change: 256 then -1536 at cnt 500.
    wait_per(4);
    lft_spd = 12'h100;
    push(5, 0, 224, 1760, 64, 0);
    push(5, 1, 2015, 0, 33, 1);
    push(6, 0, 224, 1760, 64, 0);
    push(6, 1, 2015, 0, 33, 1);
    wait_per(6);
    repeat (500) tick();
    lft_spd = 12'hA00;
    push(7, 0, 1504, 480, 64, 1);
    push(7, 1, 2015, 0, 33, 1);

    // Enable dropped for 10 cycles at cnt 200 while both sides are in HI.
    wait_per(8);
    push(8, 0, 1463, 480, 105, 1);
    push(8, 1, 1974, 0, 74, 1);
    repeat (200) tick();
    mtr_en = 1'b0;
    tick();
    chk("drives low after disable", int'({lft_hi, lft_lo, rght_hi, rght_lo}), 0);
    repeat (9) tick();
    mtr_en = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!lft_hi && n < 100) begin
      tick();
      n++;
      if (!lft_hi) seen = seen | lft_lo | rght_hi | rght_lo;
    end
    chk("dead cycles after re-enable", n, 32);
    chk("rght_hi resumes with lft_hi", int'(rght_hi), 1);
    chk("drive during re-enable dead time", int'(seen), 0);

    // Small duty is swallowed by the minimum-pulse suppression.
    wait_per(9);
    lft_spd = 12'h014;
    push(10, 0, 0, 1996, 52, 0);
    push(10, 1, 2015, 0, 33, 1);
    push(11, 0, 0, 1996, 52, 0);
    push(11, 1, 2015, 0, 33, 1);
    wait_per(12);

    chk("expectation queue drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mtr_pwm_drv.md
# mtr_pwm_drv

- Sits directly downstream of the balance-math stage.
- Converts the signed left and right speed commands into H-bridge gate drives for the two wheel motors.
- Each motor gets:
  - an 11-bit PWM on a free-running 2048-cycle period,
  - a registered direction flag,
  - complementary high/low drives with guaranteed non-overlap (dead) time.
- Emits a once-per-period sync pulse for the rest of the design.

## Interface
- `NONOVERLAP`, default `32`: dead-time length in clk cycles. Legal range is 2..255.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `lft_spd` in 12: signed left speed command; full range `12'h800`..`12'h7FF`.
- `rght_spd` in 12: signed right speed command.
- `mtr_en` in 1: motor enable. When 0, all four gate drives are forced low.
- `lft_hi` out 1: left bridge high-side drive.
- `lft_lo` out 1: left bridge low-side drive.
- `rght_hi` out 1: right bridge high-side drive.
- `rght_lo` out 1: right bridge low-side drive.
- `lft_rev` out 1: left direction; 1 = reverse.
- `rght_rev` out 1: right direction; 1 = reverse.
- `pwm_synch` out 1: one-cycle pulse at each period start.

## Operation
- **Period counter:** 11-bit `cnt`, reset 0, increments every clk, wraps `2047` → `0`.
- **`pwm_synch`:** registered; loads `(cnt == 2047)`, so it is high exactly in the cycles where `cnt == 0`. It is 0 in the first period after reset.
- **Shadow load:** in the cycle where `cnt == 2047`, per side:
  - `duty_x <= |spd_x|`, saturated to 11 bits (`-2048` → `2047`);
  - `rev_x <= spd_x[11]`.
  - Commands applied at any other time have no effect until the next wrap.
- **Raw PWM per side:** `raw = (cnt < duty)`.
  - `duty = 0` gives raw always low.
  - `duty = 2047` gives raw low only when `cnt == 2047`.
- **Non-overlap FSM per side.** States are `DEAD`, `HI`, `LO`, with an 8-bit dead counter `dcnt`.
  - `DEAD`: both drives low. `dcnt` increments each cycle.
    - If `raw` differs from its previous-cycle value, `dcnt` restarts at 0.
    - When `dcnt == NONOVERLAP-1`, go to `HI` if `raw`, else `LO`.
  - `HI`: `hi = 1`. When `raw == 0`, go to `DEAD` with `dcnt = 0`.
  - `LO`: `lo = 1`. When `raw == 1`, go to `DEAD` with `dcnt = 0`.
  - `hi`/`lo` are decoded from the state register, so they are glitch-free and never both 1.
- **`mtr_en == 0`:** synchronously forces `DEAD` and `dcnt = 0` on both sides every cycle. Drives are low from the next edge. When `mtr_en` returns to 1, a full `NONOVERLAP` dead time elapses before any drive asserts.
- **Short pulses:** a raw pulse of `NONOVERLAP` cycles or fewer never produces a `hi` (or `lo`) pulse. This is intended minimum-pulse suppression.
- **Reset state (`rst_n` low, asynchronous):**
  - `cnt = 0`, `duty = 0`, `rev = 0`, `pwm_synch = 0`;
  - FSMs in `DEAD` with `dcnt = 0`;
  - all drive outputs 0.

## Timing
- **Raw-edge latency:** one cycle from a raw edge to the falling edge of the active drive.
- **Dead-time latency:** `NONOVERLAP + 1` cycles from a raw edge to the opposite drive rising.
- **Per-period drive counts** when `NONOVERLAP < duty < 2048 - NONOVERLAP`:
  - `hi` high for `duty - NONOVERLAP` cycles;
  - `lo` high for `2048 - duty - NONOVERLAP` cycles.
- **Command-to-output latency:** a speed change appears at most 2048 cycles after being applied, aligned to `cnt == 0`.
- **Direction changes:** `rev_x` changes only at `cnt == 0`, coincident with the new duty.
- **Simultaneous events:** wrap and `mtr_en` falling in the same cycle means the shadow still loads and the drives go low. Reset overrides everything.

## Structure
- **Package `mtr_drv_pkg`:** `PWM_W = 11`, `PWM_MAX = 11'h7FF`, and the FSM state enum `nonovl_state_t` (`DEAD`, `HI`, `LO`).
- **Sub-module `pwm_nonovl`:** parameter `NONOVERLAP`; ports `clk`, `rst_n`, `raw`, `en`, `hi`, `lo`. Instantiated once per side.
- **Top level:** counter, shadow registers, saturation/abs logic, compare, `pwm_synch`.

## Test plan
- **Reset:** `rst_n` low mid-HI → all outputs 0 with no clock edge. Release with `spd = 0` → `lo` rises exactly 32 cycles later, `hi` never asserts.
- **Half duty:** `lft_spd = 12'h400` → each period `hi` high 992 cycles, `lo` high 992 cycles, two 32-cycle dead gaps, `lft_rev = 0`.
- **Negative full scale:** `rght_spd = 12'h800` → `rght_rev = 1` from the next `cnt == 0`; `rght_lo` never asserts; `rght_hi` low for 33 cycles per period.
- **Mid-period command change:** `lft_spd` changes `12'h100` → `12'hA00` at `cnt == 500` → current period keeps duty 256. From the next `cnt == 0`, duty is 1536 and `lft_rev = 1`.
- **Enable toggle:** `mtr_en` low for 10 cycles during `HI` → all drives 0 one cycle later. After re-enable, 32 dead cycles, then the drive matches `raw`.
- **Small duty:** `lft_spd = 12'h014` (20 < `NONOVERLAP`) → `lft_hi` never asserts. `pwm_synch` pulses every 2048 cycles throughout.
